adjust_ctrl: RTL

- Upstream of the time-adjust counter block in the digital-clock design.
- Debounces the four raw front-panel keys (MODE, SEL, UP, DOWN) and runs the mode/field FSM: RUN, SET_TIME, SET_ALARM.
- Produces the per-field H/M/S UP/DOWN adjust levels, the PE load pulse and the commit strobes consumed by the adjust counters, timer and alarm register.
- Returns to RUN automatically after a period with no key activity.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/adjust_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared encodings and default timing constants for the clock adjust path
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_HOUR   = 2'b00,
        FIELD_MINUTE = 2'b01,
        FIELD_SECOND = 2'b10
    } field_e;

    localparam int DEF_DEB_CYCLES = 20;
    localparam int DEF_TIMEOUT    = 30000;
    localparam int DEF_BLINK_HALF = 500;

    function automatic field_e field_step(input field_e f);
        case (f)
            FIELD_HOUR:   return FIELD_MINUTE;
            FIELD_MINUTE: return FIELD_SECOND;
            default:      return FIELD_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus counter debounce for one raw key
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic stable,
    output logic flip
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // flip is a one-cycle pulse coincident with the new stable level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            flip   <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            flip  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt    <= '0;
                stable <= sync2;
                flip   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adjust_ctrl.sv
// rtl/adjust_ctrl.sv - key debounce, mode/field FSM, timeout and blink for time/alarm adjust
module adjust_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       KEY_MODE,
    input  logic       KEY_SEL,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    output logic [1:0] MODE,
    output logic [1:0] FIELD,
    output logic       H_UP,
    output logic       H_DOWN,
    output logic       M_UP,
    output logic       M_DOWN,
    output logic       S_UP,
    output logic       S_DOWN,
    output logic       PE,
    output logic       COMMIT_T,
    output logic       COMMIT_A,
    output logic       BLINK
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic mode_lvl, sel_lvl, up_lvl, down_lvl;
    logic mode_flip, sel_flip, up_flip, down_flip;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(CP), .rst(CR), .key(KEY_MODE), .stable(mode_lvl), .flip(mode_flip));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .clk(CP), .rst(CR), .key(KEY_SEL), .stable(sel_lvl), .flip(sel_flip));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(CP), .rst(CR), .key(KEY_UP), .stable(up_lvl), .flip(up_flip));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(CP), .rst(CR), .key(KEY_DOWN), .stable(down_lvl), .flip(down_flip));

    logic mode_press, sel_press, key_activity;
    assign mode_press   = mode_flip & mode_lvl;
    assign sel_press    = sel_flip & sel_lvl;
    assign key_activity = mode_flip | sel_flip | up_flip | down_flip;

    mode_e         state, state_nx;
    field_e        field, field_nx;
    logic [TW-1:0] tmo_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_tog;
    logic [5:0]    adj_q, adj_nx;
    logic          pe_q, commit_t_q, commit_a_q;
    logic          set_mode, tmo_hit, entering, up_only, down_only;

    assign set_mode  = (state != MODE_RUN);
    assign tmo_hit   = set_mode && (tmo_cnt == TMO_MAX);
    assign entering  = (state_nx != state) && (state_nx != MODE_RUN);
    assign up_only   = up_lvl & ~down_lvl;
    assign down_only = down_lvl & ~up_lvl;

    // MODE press outranks both timeout and a same-cycle SEL press
    always_comb begin
        state_nx = state;
        field_nx = field;
        if (mode_press) begin
            case (state)
                MODE_RUN:      state_nx = MODE_SET_TIME;
                MODE_SET_TIME: state_nx = MODE_SET_ALARM;
                default:       state_nx = MODE_RUN;
            endcase
            field_nx = FIELD_HOUR;
        end else if (tmo_hit) begin
            state_nx = MODE_RUN;
            field_nx = FIELD_HOUR;
        end else if (sel_press && set_mode) begin
            field_nx = field_step(field);
        end
    end

    // adjust pair is decoded against the next field so it tracks FIELD exactly
    always_comb begin
        adj_nx = 6'b0;
        if (state_nx != MODE_RUN && !entering) begin
            case (field_nx)
                FIELD_HOUR:   adj_nx = {up_only, down_only, 4'b0};
                FIELD_MINUTE: adj_nx = {2'b0, up_only, down_only, 2'b0};
                FIELD_SECOND: adj_nx = {4'b0, up_only, down_only};
                default:      adj_nx = 6'b0;
            endcase
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state      <= MODE_RUN;
            field      <= FIELD_HOUR;
            pe_q       <= 1'b0;
            commit_t_q <= 1'b0;
            commit_a_q <= 1'b0;
            adj_q      <= 6'b0;
        end else begin
            state      <= state_nx;
            field      <= field_nx;
            pe_q       <= entering;
            commit_t_q <= (state == MODE_SET_TIME) && (state_nx != MODE_SET_TIME);
            commit_a_q <= (state == MODE_SET_ALARM) && (state_nx != MODE_SET_ALARM);
            adj_q      <= adj_nx;
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            tmo_cnt <= '0;
        end else if (!set_mode || state_nx != state || key_activity || up_lvl || down_lvl) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            blink_cnt <= '0;
            blink_tog <= 1'b0;
        end else if (state_nx == MODE_RUN) begin
            blink_cnt <= '0;
            blink_tog <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_tog <= ~blink_tog;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign MODE     = state;
    assign FIELD    = field;
    assign {H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN} = adj_q;
    assign PE       = pe_q;
    assign COMMIT_T = commit_t_q;
    assign COMMIT_A = commit_a_q;
    assign BLINK    = set_mode && (blink_tog || (|adj_q));

endmodule
